dma_reader: RTL
===============

# dma_reader

Read-side DMA engine: the counterpart of the ROM-to-RAM copy engine. On a start request it streams a block of words out of the shared RAM, beginning at a base address, and presents them on a valid/ready output stream. It sits between the RAM read port and any downstream consumer (UART transmitter, checker, display), absorbing backpressure without dropping or duplicating words.

## Interface
- DATA_WIDTH, 8, RAM word width
- DEPTH, 4, RAM depth in words
- LEN_WIDTH, 16, width of the transfer-length input
- ADDR_WIDTH, $clog2(DEPTH), localparam, RAM address width
- clk  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  start request, sampled only in IDLE
- base_addr  input  ADDR_WIDTH  first RAM address of the transfer
- length  input  LEN_WIDTH  number of words to transfer (0 allowed)
- ram_re  output  1  RAM read enable
- ram_addr  output  ADDR_WIDTH  RAM read address
- ram_rdata  input  DATA_WIDTH  RAM read data, valid one cycle after ram_re
- out_data  output  DATA_WIDTH  stream data
- out_valid  output  1  stream data valid
- out_ready  input  1  consumer accepts out_data when out_valid & out_ready
- busy  output  1  high from the cycle after start is taken until done
- done  output  1  one-cycle pulse at end of transfer

## Operation
- Reset values: ram_re=0, ram_addr=0, out_data=0, out_valid=0, busy=0, done=0; FSM in IDLE; counters 0; buffer empty.
- States: IDLE -> READ (start=1, length!=0); IDLE -> DONE (start=1, length==0); READ -> DRAIN (last read issued); DRAIN -> DONE (buffer empty and no read in flight); DONE -> IDLE (unconditional, one cycle).
- start latches base_addr and length; start in any state other than IDLE is ignored.
- Read issue: ram_re=1 in READ only when occupancy + in-flight < 2, so ram_rdata always has a free slot one cycle later.
- ram_addr increments after every issued read, wrapping modulo DEPTH (DEPTH need not be a power of two; wrap at DEPTH-1 -> 0).
- issued counter counts reads; accepted counter counts handshakes; both LEN_WIDTH bits; transfer complete when accepted == latched length.
- Output buffer: 2-entry FIFO, head drives out_data/out_valid; out_data holds stable while out_valid=1 and out_ready=0.
- Simultaneous write (returning read data) and pop (handshake) in one cycle: both occur, occupancy unchanged.
- Asynchronous reset mid-transfer: all state returns to reset values immediately; in-flight data discarded; no done pulse.

## Timing
- Start taken at edge N: busy=1 and ram_re=1 with ram_addr=base_addr after edge N.
- First word: out_valid=1 after edge N+2.
- With out_ready held high: one word per cycle, ram_re continuous, length L finishes with done pulse after edge N+L+2.
- length=0: done=1 after edge N+1 for one cycle, busy stays 0, no ram_re.
- done asserts the cycle after the final handshake; busy drops in the same cycle done rises.
- out_ready low: at most 2 words buffered; ram_re deasserts within one cycle; reads resume the cycle after a pop frees a slot.

## Structure
- Package dma_pkg: state enum typedef (IDLE, READ, DRAIN, DONE) shared with the write engine; ram address width helper.
- Sub-module dma_skid_fifo: 2-entry parameterised FIFO (push, pop, data, count), reusable by the write engine.
- Top dma_reader: FSM, address/issue/accept counters, in-flight flag, FIFO instance.

## Test plan
- RAM preloaded 0x11,0x22,0x33,0x44; base_addr=0, length=4, out_ready=1 -> out stream 11,22,33,44 on 4 consecutive cycles, done pulse one cycle after last, busy then 0.
- base_addr=2, length=4 -> ram_addr sequence 2,3,0,1; out stream 33,44,11,22.
- length=4, out_ready toggled 1,0,0,1,0,1... -> no loss or duplication, out_data stable while stalled, ≤2 buffered, ram_re never exceeds free slots.
- length=0 -> single done pulse the cycle after start, no ram_re, out_valid never asserted.
- start pulsed again mid-transfer (different base_addr) -> ignored; original stream completes unchanged.
- reset asserted low after 2 of 4 words accepted -> all outputs 0 immediately; new start after release delivers a full fresh transfer from its base_addr.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA read and write engines.
package dma_pkg;

   // Transfer sequencing shared by both engines.
   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN,
      DONE
   } dma_state_e;

   // RAM address width for a given depth; never narrower than one bit.
   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/dma_reader_if.sv
// RAM read port plus valid/ready output stream of the DMA read engine.
interface dma_reader_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 2
);
   logic                  ram_re;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;

   // DMA engine side.
   modport master (
      output ram_re, ram_addr, out_data, out_valid,
      input  ram_rdata, out_ready
   );

   // RAM and consumer side.
   modport slave (
      input  ram_re, ram_addr, out_data, out_valid,
      output ram_rdata, out_ready
   );
endinterface

// File: rtl/dma_skid_fifo.sv
// Two-entry FIFO; the head entry is always visible on head.
module dma_skid_fifo #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] mem_q [2];
   logic [WIDTH-1:0] mem_d [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             do_push, do_pop;

   // A pop frees a slot in the same cycle, so push into a full FIFO is legal then.
   assign do_pop  = pop && (count_q != 2'd0);
   assign do_push = push && ((count_q != 2'd2) || do_pop);
   assign head    = mem_q[rd_ptr_q];
   assign count   = count_q;

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // State registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: storage is reset too, so the head reads 0 out of reset; cheap at two entries.
         mem_q    <= '{default: '0};
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/dma_reader.sv
// Read-side DMA engine: streams a block of RAM words out on a valid/ready stream.
module dma_reader
   import dma_pkg::*;
#(
   parameter  int DATA_WIDTH = 8,
   parameter  int DEPTH      = 4,
   parameter  int LEN_WIDTH  = 16,
   localparam int ADDR_WIDTH = addr_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  length,
   output logic                  busy,
   output logic                  done,
   dma_reader_if.master          bus
);

   dma_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [LEN_WIDTH-1:0]  issued_q, issued_d;
   logic [LEN_WIDTH-1:0]  accepted_q, accepted_d;
   logic                  in_flight_q, in_flight_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic [1:0]            fifo_count;
   logic [DATA_WIDTH-1:0] fifo_head;
   logic                  pop;
   logic                  read_en;
   logic [2:0]            slots_used;

   // Word returning from RAM this cycle lands in the FIFO at the next edge.
   dma_skid_fifo #(.WIDTH(DATA_WIDTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (in_flight_q),
      .push_data (bus.ram_rdata),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   assign bus.out_valid = (fifo_count != 2'd0);
   assign bus.out_data  = fifo_head;
   assign pop           = bus.out_valid && bus.out_ready;

   // Slots the FIFO must still hold once this cycle ends. The read-enable sees a
   // same-cycle pop, which is what keeps reads back-to-back while the consumer
   // is ready; a read issued now lands one cycle later in a guaranteed free slot.
   assign slots_used = {1'b0, fifo_count} - {2'b00, pop} + {2'b00, in_flight_q};
   assign read_en    = (state_q == READ) && (issued_q != len_q) && (slots_used < 3'd2);

   assign bus.ram_re   = read_en;
   assign bus.ram_addr = addr_q;
   assign busy         = busy_q;
   assign done         = done_q;

   // Transfer sequencing, address walk and issue/accept bookkeeping.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      len_d       = len_q;
      issued_d    = issued_q;
      accepted_d  = accepted_q;
      in_flight_d = read_en;
      busy_d      = busy_q;
      done_d      = 1'b0;

      if (read_en) begin
         addr_d   = (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
         issued_d = issued_q + 1'b1;
      end
      if (pop) begin
         accepted_d = accepted_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               addr_d     = base_addr;
               len_d      = length;
               issued_d   = '0;
               accepted_d = '0;
               if (length != '0) begin
                  state_d = READ;
                  busy_d  = 1'b1;
               end else begin
                  state_d = DONE;
               end
            end
         end
         READ: begin
            if (read_en && (issued_d == len_q)) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Final handshake empties the buffer with nothing left in flight.
            if (pop && (accepted_d == len_q)) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            // An empty transfer reports done as it leaves DONE, one cycle after start.
            done_d  = (len_q == '0);
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset abandons any transfer and discards in-flight data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         len_q       <= '0;
         issued_q    <= '0;
         accepted_q  <= '0;
         in_flight_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         issued_q    <= issued_d;
         accepted_q  <= accepted_d;
         in_flight_q <= in_flight_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

endmodule
